// File: rtl/pair_deser_pkg.sv
// Shared constants and types for the pair deserializer.
//   BEATS / BEAT_W / BYTE_W / CNT_W : framing widths
//   ST_*                            : status word bit positions
//   state_e                         : sequencing FSM states
package pair_deser_pkg;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BIDX_W = $clog2(BEATS);

  localparam int unsigned ST_FULL    = 7;
  localparam int unsigned ST_OVR     = 6;
  localparam int unsigned ST_BEAT_HI = 5;
  localparam int unsigned ST_BEAT_LO = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/user_module_pair_deserializer_if.sv
// TinyTapeout 8-in/8-out user-module pin frame.
//   io_in[0] clk, [1] rst_n, [2] valid, [3] din_a, [4] din_b,
//   [5] mode, [6] ack, [7] count_clr
//   io_out   held byte (mode=0) or status word (mode=1)
interface user_module_pair_deserializer_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/pair_shift_collector.sv
// Packs (din_a, din_b) pairs LSB-first into a byte, one pair per valid edge.
//   clk, rst_n     : clock, async active-low reset
//   valid          : sample a pair this edge
//   din_a, din_b   : pair bits (din_b -> even bit, din_a -> odd bit)
//   beat           : index of the next pair to be written
//   done_c         : this edge delivers the last pair of a byte
//   byte_c         : assembled byte including the current pair
module pair_shift_collector
  import pair_deser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              din_a,
  input  logic              din_b,
  output logic [BIDX_W-1:0] beat,
  output logic              done_c,
  output logic [BYTE_W-1:0] byte_c
);

  logic [BYTE_W-1:0] shreg;

  // Pair write and beat advance; beat wraps naturally after the last pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      beat  <= '0;
    end else if (valid) begin
      shreg[32'(beat) * BEAT_W +: BEAT_W] <= {din_a, din_b};
      beat <= beat + BIDX_W'(1);
    end
  end

  // Completion view: top pair comes straight from the inputs this edge.
  assign done_c = valid && (beat == BIDX_W'(BEATS - 1));
  assign byte_c = {din_a, din_b, shreg[BYTE_W-BEAT_W-1:0]};

endmodule

// File: rtl/user_module_pair_deserializer.sv
// Pair deserializer with a one-entry holding register, ack handshake,
// overrun flag, accepted-byte counter and a mode-selected status view.
//   pins.io_in  : clk, rst_n, valid, din_a, din_b, mode, ack, count_clr
//   pins.io_out : held byte (mode=0) or status word (mode=1)
module user_module_pair_deserializer
  import pair_deser_pkg::*;
(
  user_module_pair_deserializer_if.slave pins
);

  logic clk, rst_n, valid, din_a, din_b, mode, ack, count_clr;

  assign clk       = pins.io_in[0];
  assign rst_n     = pins.io_in[1];
  assign valid     = pins.io_in[2];
  assign din_a     = pins.io_in[3];
  assign din_b     = pins.io_in[4];
  assign mode      = pins.io_in[5];
  assign ack       = pins.io_in[6];
  assign count_clr = pins.io_in[7];

  logic [BIDX_W-1:0] beat;
  logic              done_c;
  logic [BYTE_W-1:0] byte_c;

  pair_shift_collector u_collector (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (valid),
    .din_a  (din_a),
    .din_b  (din_b),
    .beat   (beat),
    .done_c (done_c),
    .byte_c (byte_c)
  );

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              ovr_q, ovr_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [7:0]        status_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      hold_q  <= '0;
      ovr_q   <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ovr_q   <= ovr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next state: a completion either loads (empty or acked) or is dropped.
  // An ack that accompanies a load still counts as consuming, so it clears
  // any pending overrun.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ovr_d   = ovr_q;
    bcnt_d  = bcnt_q;
    if (done_c) begin
      if (state_q == COLLECT || ack) begin
        state_d = HOLD;
        hold_d  = byte_c;
        bcnt_d  = bcnt_q + CNT_W'(1);
        if (ack) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ack) begin
      state_d = COLLECT;
      ovr_d   = 1'b0;
    end
    if (count_clr) bcnt_d = '0;
  end

  // Status word and output mux, purely from registers.
  always_comb begin
    status_c                        = '0;
    status_c[ST_FULL]               = (state_q == HOLD);
    status_c[ST_OVR]                = ovr_q;
    status_c[ST_BEAT_HI:ST_BEAT_LO] = beat;
    status_c[CNT_W-1:0]             = bcnt_q;
  end

  assign pins.io_out = mode ? status_c : hold_q;

endmodule

// File: tb/tb_user_module_pair_deserializer.sv
// Directed bench for the pair deserializer: vector table plus drain sequence.
module tb_user_module_pair_deserializer;

  logic clk, rst_n, valid, din_a, din_b, mode, ack, count_clr;

  user_module_pair_deserializer_if pins ();
  assign pins.io_in = {count_clr, ack, mode, din_b, din_a, valid, rst_n, clk};

  user_module_pair_deserializer dut (.pins(pins));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         v;
    bit         a;
    bit         b;
    bit         m;
    bit         k;
    bit         c;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_fail;

  function automatic void add(bit rst, bit v, bit a, bit b, bit m, bit k,
                              bit c, logic [7:0] exp);
    vec_t t;
    t.rst = rst; t.v = v; t.a = a; t.b = b; t.m = m; t.k = k; t.c = c;
    t.exp = exp;
    tbl.push_back(t);
  endfunction

  // Drive one cycle's inputs, then let one rising edge happen.
  task automatic drive_edge(bit rst, bit v, bit a, bit b, bit m, bit k, bit c);
    rst_n = ~rst; valid = v; din_a = a; din_b = b; mode = m; ack = k;
    count_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h required 0x%02h", nm, act, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_b;
    logic [3:0] exp_cnt;
    bit         pa, pb;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; valid = 0; din_a = 0; din_b = 0; mode = 0; ack = 0;
    count_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_byte", pins.io_out, 8'h00);
    mode = 1'b1;
    #1;
    chk("reset_status", pins.io_out, 8'h00);

    //   rst v  a  b  m  k  c  exp
    // byte 0x36 from (1,0),(0,1),(1,1),(0,0)
    add(0, 1, 1, 0, 1, 0, 0, 8'h10);
    add(0, 1, 0, 1, 1, 0, 0, 8'h20);
    add(0, 1, 1, 1, 1, 0, 0, 8'h30);
    add(0, 1, 0, 0, 0, 0, 0, 8'h36);
    add(0, 0, 0, 0, 1, 0, 0, 8'h81);
    // second byte without ack -> overrun, hold untouched; then ack
    add(0, 1, 0, 1, 1, 0, 0, 8'h91);
    add(0, 1, 0, 1, 1, 0, 0, 8'hA1);
    add(0, 1, 0, 1, 1, 0, 0, 8'hB1);
    add(0, 1, 0, 1, 1, 0, 0, 8'hC1);
    add(0, 0, 0, 0, 0, 0, 0, 8'h36);
    add(0, 0, 0, 0, 1, 1, 0, 8'h01);
    add(0, 0, 0, 0, 0, 0, 0, 8'h36);
    // reset, byte 0xAA, then 0x55 with ack on its completing edge
    add(1, 0, 0, 0, 1, 0, 0, 8'h00);
    add(0, 1, 1, 0, 1, 0, 0, 8'h10);
    add(0, 1, 1, 0, 1, 0, 0, 8'h20);
    add(0, 1, 1, 0, 1, 0, 0, 8'h30);
    add(0, 1, 1, 0, 0, 0, 0, 8'hAA);
    add(0, 1, 0, 1, 1, 0, 0, 8'h91);
    add(0, 1, 0, 1, 1, 0, 0, 8'hA1);
    add(0, 1, 0, 1, 1, 0, 0, 8'hB1);
    add(0, 1, 0, 1, 1, 1, 0, 8'h82);
    add(0, 0, 0, 0, 0, 0, 0, 8'h55);
    // two beats, reset, then four (1,1) beats
    add(0, 1, 1, 0, 1, 0, 0, 8'h92);
    add(0, 1, 1, 0, 1, 0, 0, 8'hA2);
    add(1, 0, 0, 0, 1, 0, 0, 8'h00);
    add(0, 1, 1, 1, 1, 0, 0, 8'h10);
    add(0, 1, 1, 1, 1, 0, 0, 8'h20);
    add(0, 1, 1, 1, 1, 0, 0, 8'h30);
    add(0, 1, 1, 1, 0, 0, 0, 8'hFF);
    add(0, 0, 0, 0, 1, 0, 0, 8'h81);
    // gapped delivery with junk on the pins while valid is low
    add(1, 0, 0, 0, 1, 0, 0, 8'h00);
    add(0, 1, 1, 0, 1, 0, 0, 8'h10);
    add(0, 0, 1, 1, 1, 0, 0, 8'h10);
    add(0, 1, 0, 1, 1, 0, 0, 8'h20);
    add(0, 0, 1, 0, 1, 0, 0, 8'h20);
    add(0, 1, 1, 1, 1, 0, 0, 8'h30);
    add(0, 0, 0, 1, 0, 0, 0, 8'h00);
    add(0, 1, 0, 0, 0, 0, 0, 8'h36);
    add(0, 0, 0, 0, 1, 0, 0, 8'h81);

    foreach (tbl[i]) begin
      drive_edge(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].m,
                 tbl[i].k, tbl[i].c);
      chk($sformatf("vec%0d", i), pins.io_out, tbl[i].exp);
    end

    // Free-running drain: 16 bytes with ack held high, counter wraps.
    drive_edge(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      pa = i[0];
      pb = i[1];
      for (int j = 0; j < 4; j++) drive_edge(0, 1, pa, pb, 0, 1, 0);
      exp_b   = (pa ? 8'hAA : 8'h00) | (pb ? 8'h55 : 8'h00);
      exp_cnt = 4'(i + 1);
      chk($sformatf("drain_byte%0d", i), pins.io_out, exp_b);
      mode = 1'b1;
      #1;
      chk($sformatf("drain_status%0d", i), pins.io_out, {4'h8, exp_cnt});
    end

    // count_clr on a completing edge beats the increment.
    for (int j = 0; j < 4; j++) drive_edge(0, 1, 1, 0, 1, 1, (j == 3));
    chk("clr_on_completion", pins.io_out, 8'h80);
    for (int j = 0; j < 4; j++) drive_edge(0, 1, 0, 1, 1, 1, 0);
    chk("count_after_clr", pins.io_out, 8'h81);
    drive_edge(0, 0, 0, 0, 1, 0, 1);
    chk("clr_idle", pins.io_out, 8'h80);
    mode = 1'b0;
    #1;
    chk("hold_after_clr", pins.io_out, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
